pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline; it gates the pipeline-register enables and bubbles.
//  Detects load-use hazards the forwarding path cannot cover, freezes the pipe for multi-cycle EXE ops,
//  and freezes it for data-memory wait states. Applies branch/jump flushes.
//  Sits beside the forwarding logic. It drives pc_en and the IF_ID, ID_EXE and EXE_MEM enables and flushes.
// PARAMETERS
//  MC_LAT       4    cycles a multi-cycle EXE op occupies EXE (>=1; 1 = no stall)
//  MEM_TIMEOUT  255  max cycles in MEM_WAIT before mem_timeout_err sets (>=1)
// PORTS
//  clk                 in   1  clock, rising edge
//  arst_n              in   1  reset, synchronous, active-low
//  id_exe_mem_read     in   1  instruction in ID_EXE is a load
//  id_exe_waddr        in   5  destination register of ID_EXE instruction
//  if_id_rs            in   5  Rs of IF_ID instruction
//  if_id_rt            in   5  Rt of IF_ID instruction
//  if_id_uses_rt       in   1  IF_ID instruction reads Rt as a source
//  exe_branch_taken    in   1  branch/jump in EXE resolved taken
//  exe_multicycle      in   1  instruction in EXE is a multi-cycle op (level)
//  mem_req             in   1  MEM stage issues a data-memory access
//  mem_ready           in   1  data memory completes the access this cycle
//  pc_en               out  1  PC register update enable
//  if_id_en            out  1  IF_ID register enable
//  if_id_flush         out  1  IF_ID loads a NOP
//  id_exe_en           out  1  ID_EXE register enable
//  id_exe_flush        out  1  ID_EXE loads a bubble (control bits zero)
//  exe_mem_en          out  1  EXE_MEM register enable (MEM_WB shares this enable)
//  exe_mem_flush       out  1  EXE_MEM loads a bubble
//  mem_timeout_err     out  1  sticky error: MEM_WAIT exceeded MEM_TIMEOUT
// BEHAVIOUR
//  States: RUN, MC_BUSY, MEM_WAIT. A down-counter cnt has width $clog2(max(MC_LAT,MEM_TIMEOUT)+1).
//  Reset (arst_n=0 at edge): state<=RUN, cnt<=0, mem_timeout_err<=0.
//  While arst_n=0, outputs are forced: all *_en=0, all *_flush=1.
//  Outputs are combinational from state, cnt and inputs. Defaults: every *_en=1, every *_flush=0.
//  Priority in RUN, evaluated top-down; first match wins:
//   1 mem_req & !mem_ready: all *_en=0 this cycle; next MEM_WAIT; cnt<=MEM_TIMEOUT-1.
//   2 exe_multicycle & MC_LAT>1: pc_en=if_id_en=id_exe_en=0, exe_mem_flush=1; next MC_BUSY; cnt<=MC_LAT-2.
//   3 exe_branch_taken: if_id_flush=1, id_exe_flush=1, pc_en=1 (target loads). A load-use hit is ignored.
//   4 load-use: id_exe_mem_read & id_exe_waddr!=0 & (id_exe_waddr==if_id_rs | (if_id_uses_rt & id_exe_waddr==if_id_rt))
//     -> pc_en=0, if_id_en=0, id_exe_flush=1 for exactly 1 cycle. Stay in RUN.
//  MC_BUSY, cnt>0: pc_en=if_id_en=id_exe_en=0, exe_mem_flush=1; cnt<=cnt-1.
//  MC_BUSY, cnt==0: defaults (result latches into EXE_MEM); next RUN.
//   -> total freeze = MC_LAT-1 cycles.
//   Branch and load-use checks are suppressed in MC_BUSY. They are re-evaluated in RUN after release.
//   A mem_req&!mem_ready in MC_BUSY freezes all stages; cnt holds; state stays MC_BUSY.
//  MEM_WAIT: all *_en=0 while !mem_ready.
//   On mem_ready: defaults; next RUN.
//   If cnt==0 & !mem_ready: mem_timeout_err<=1 (sticky until reset); stay in MEM_WAIT.
//   Otherwise cnt decrements.
//   Inputs exe_branch_taken and exe_multicycle are held by the frozen pipe and are acted on after release.
//  Back-to-back multi-cycle ops: the next op reaches EXE in the cycle after release and re-enters MC_BUSY.
//  Reset mid-stall: the pipe returns to RUN on the next edge. No partial counts survive.
//  Output invariants: never *_en=0 together with *_flush=1 on the same register, except during reset.
// STRUCTURE
//  Package hazard_pkg holds: state encoding localparams (RUN=2'd0, MC_BUSY=2'd1, MEM_WAIT=2'd2) and REG_ZERO=5'd0.
//  Sub-module stall_counter: loadable down-counter with load, dec, zero outputs and WIDTH param.
//   It is reused for MC and MEM timeouts.
//  The top level contains the FSM register and the combinational output decode.
// TESTING
//  1 Load-use: id_exe_mem_read=1, id_exe_waddr=5, if_id_rs=5 -> 1 cycle of pc_en=0, if_id_en=0, id_exe_flush=1, then defaults.
//  2 Zero-reg and rt gating: waddr=0 with rs=0 -> no stall.
//    waddr=7, rt=7, uses_rt=0 -> no stall; uses_rt=1 -> stall.
//  3 MC_LAT=4, exe_multicycle pulse -> exactly 3 cycles of id_exe_en=0 and exe_mem_flush=1.
//    exe_mem_en=1 and flushes=0 on the release cycle.
//  4 mem_req=1, mem_ready low for 3 cycles -> all enables 0 for 3 cycles; defaults on the mem_ready cycle; state RUN.
//  5 MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err=1 after the 5th stalled cycle; stays 1 until arst_n=0.
//  6 Branch taken plus load-use hit in the same cycle -> if_id_flush=id_exe_flush=1, pc_en=1, no stall.
//    arst_n=0 during MC_BUSY -> RUN next edge.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller.
// State codes, the zero-register index and a small sizing helper.
package hazard_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MC_BUSY  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN  = RUN,
    ST_MC   = MC_BUSY,
    ST_MEM  = MEM_WAIT
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_stall_counter.sv
// Loadable down-counter shared by multi-cycle and memory-wait stalls.
// Saturates at zero; load has priority over decrement.
module stall_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: load-use, multi-cycle EXE, memory wait
// states and taken-branch flushes for the 5-stage pipe.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MC_LAT      = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       id_exe_mem_read,
  input  logic [4:0] id_exe_waddr,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  input  logic       exe_branch_taken,
  input  logic       exe_multicycle,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_exe_en,
  output logic       id_exe_flush,
  output logic       exe_mem_en,
  output logic       exe_mem_flush,
  output logic       mem_timeout_err
);

  localparam int CW = $clog2(max2(MC_LAT, MEM_TIMEOUT) + 1);
  localparam int MC_LOAD_I = (MC_LAT > 1) ? (MC_LAT - 2) : 0;
  localparam logic [CW-1:0] MC_LOAD  = CW'(MC_LOAD_I);
  localparam logic [CW-1:0] MEM_LOAD = CW'(MEM_TIMEOUT - 1);
  localparam bit MC_EN = (MC_LAT > 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_err;
  logic            w_err_set;
  logic            w_load;
  logic [CW-1:0]   w_load_val;
  logic            w_dec;
  logic            w_zero;
  logic [CW-1:0]   w_cnt;
  logic            w_lu;
  logic            w_mstall;

  stall_counter #(.WIDTH(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (arst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  assign w_mstall = mem_req && !mem_ready;
  assign w_lu = id_exe_mem_read
             && (id_exe_waddr != REG_ZERO)
             && ((id_exe_waddr == if_id_rs)
              || (if_id_uses_rt && (id_exe_waddr == if_id_rt)));

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state <= ST_RUN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_en     = 1'b1;
    id_exe_flush  = 1'b0;
    exe_mem_en    = 1'b1;
    exe_mem_flush = 1'b0;
    w_next        = r_state;
    w_load        = 1'b0;
    w_load_val    = '0;
    w_dec         = 1'b0;
    w_err_set     = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_mstall) begin
          {pc_en, if_id_en, id_exe_en, exe_mem_en} = 4'b0000;
          w_next     = ST_MEM;
          w_load     = 1'b1;
          w_load_val = MEM_LOAD;
        end else if (exe_multicycle && MC_EN) begin
          {pc_en, if_id_en, id_exe_en} = 3'b000;
          exe_mem_flush = 1'b1;
          w_next        = ST_MC;
          w_load        = 1'b1;
          w_load_val    = MC_LOAD;
        end else if (exe_branch_taken) begin
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
        end else if (w_lu) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_exe_flush = 1'b1;
        end
      end
      ST_MC: begin
        // memory stall wins: freeze everything and hold the count
        if (w_mstall) begin
          {pc_en, if_id_en, id_exe_en, exe_mem_en} = 4'b0000;
        end else if (!w_zero) begin
          {pc_en, if_id_en, id_exe_en} = 3'b000;
          exe_mem_flush = 1'b1;
          w_dec         = 1'b1;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          w_next = ST_RUN;
        end else begin
          {pc_en, if_id_en, id_exe_en, exe_mem_en} = 4'b0000;
          if (w_zero)
            w_err_set = 1'b1;
          else
            w_dec = 1'b1;
        end
      end
      default: w_next = ST_RUN;
    endcase
    if (!arst_n) begin
      {pc_en, if_id_en, id_exe_en, exe_mem_en} = 4'b0000;
      {if_id_flush, id_exe_flush, exe_mem_flush} = 3'b111;
    end
  end

  assign mem_timeout_err = r_err;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller.
// Output vector = {pc,ifid_en,ifid_fl,idexe_en,idexe_fl,exemem_en,exemem_fl}.
module tb_pipeline_hazard_controller;

  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] MCF = 7'b0000011;
  localparam logic [6:0] LUS = 7'b0001110;
  localparam logic [6:0] BRF = 7'b1111110;
  localparam logic [6:0] RST = 7'b0010101;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       id_exe_mem_read;
  logic [4:0] id_exe_waddr;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       if_id_uses_rt;
  logic       exe_branch_taken;
  logic       exe_multicycle;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_exe_en;
  logic       id_exe_flush;
  logic       exe_mem_en;
  logic       exe_mem_flush;
  logic       mem_timeout_err;
  logic [6:0] w_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .MC_LAT      (4),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .id_exe_mem_read  (id_exe_mem_read),
    .id_exe_waddr     (id_exe_waddr),
    .if_id_rs         (if_id_rs),
    .if_id_rt         (if_id_rt),
    .if_id_uses_rt    (if_id_uses_rt),
    .exe_branch_taken (exe_branch_taken),
    .exe_multicycle   (exe_multicycle),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .if_id_flush      (if_id_flush),
    .id_exe_en        (id_exe_en),
    .id_exe_flush     (id_exe_flush),
    .exe_mem_en       (exe_mem_en),
    .exe_mem_flush    (exe_mem_flush),
    .mem_timeout_err  (mem_timeout_err)
  );

  assign w_o = {pc_en, if_id_en, if_id_flush, id_exe_en,
                id_exe_flush, exe_mem_en, exe_mem_flush};

  task automatic chk(input string tag, input logic [6:0] got,
                     input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
  endtask

  initial begin
    arst_n = 1'b0;
    id_exe_mem_read = 0; id_exe_waddr = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_uses_rt = 0; exe_branch_taken = 0; exe_multicycle = 0;
    mem_req = 0; mem_ready = 0;
    adv; adv;
    look;
    chk("rst_out", w_o, RST);
    chk("rst_err", {6'd0, mem_timeout_err}, 7'd0);
    arst_n = 1'b1;
    #1 chk("idle", w_o, DEF);
    adv;

    // load-use on rs
    id_exe_mem_read = 1; id_exe_waddr = 5'd5; if_id_rs = 5'd5;
    look; chk("lu_rs", w_o, LUS);
    adv;
    id_exe_mem_read = 0;
    look; chk("lu_after", w_o, DEF);
    adv;

    // zero register never stalls
    id_exe_mem_read = 1; id_exe_waddr = 5'd0; if_id_rs = 5'd0;
    look; chk("lu_zero", w_o, DEF);
    adv;
    id_exe_waddr = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7; if_id_uses_rt = 0;
    look; chk("lu_rt_unused", w_o, DEF);
    adv;
    if_id_uses_rt = 1;
    look; chk("lu_rt_used", w_o, LUS);
    adv;
    id_exe_mem_read = 0; if_id_uses_rt = 0;

    // multi-cycle op: 3 freeze cycles then release
    exe_multicycle = 1;
    look; chk("mc_0", w_o, MCF);
    adv;
    exe_multicycle = 0;
    for (int i = 1; i < 3; i++) begin
      look; chk($sformatf("mc_%0d", i), w_o, MCF);
      adv;
    end
    look; chk("mc_release", w_o, DEF);
    adv;
    look; chk("mc_run", w_o, DEF);
    adv;

    // memory wait of 3 cycles
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      look; chk($sformatf("mw_%0d", i), w_o, FRZ);
      adv;
    end
    mem_ready = 1;
    look; chk("mw_ready", w_o, DEF);
    adv;
    mem_req = 0; mem_ready = 0;
    look; chk("mw_run", w_o, DEF);
    chk("mw_noerr", {6'd0, mem_timeout_err}, 7'd0);
    adv;

    // memory timeout sets after 5th stalled cycle
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      look; chk($sformatf("to_frz_%0d", i), w_o, FRZ);
      chk($sformatf("to_pre_%0d", i), {6'd0, mem_timeout_err}, 7'd0);
      adv;
    end
    look; chk("to_set", {6'd0, mem_timeout_err}, 7'd1);
    chk("to_still", w_o, FRZ);
    adv;
    mem_ready = 1;
    look; chk("to_ready", w_o, DEF);
    adv;
    mem_req = 0; mem_ready = 0;
    look; chk("to_sticky", {6'd0, mem_timeout_err}, 7'd1);
    arst_n = 0;
    adv;
    arst_n = 1;
    look; chk("to_clear", {6'd0, mem_timeout_err}, 7'd0);
    chk("to_run", w_o, DEF);
    adv;

    // branch beats load-use
    exe_branch_taken = 1; id_exe_mem_read = 1;
    id_exe_waddr = 5'd9; if_id_rs = 5'd9;
    look; chk("br_lu", w_o, BRF);
    adv;
    exe_branch_taken = 0; id_exe_mem_read = 0;

    // memory stall inside MC_BUSY holds the count
    exe_multicycle = 1;
    adv;
    exe_multicycle = 0; mem_req = 1; mem_ready = 0;
    look; chk("mcm_frz", w_o, FRZ);
    adv;
    mem_req = 0;
    look; chk("mcm_a", w_o, MCF);
    adv;
    look; chk("mcm_b", w_o, MCF);
    adv;
    look; chk("mcm_rel", w_o, DEF);
    adv;

    // reset during MC_BUSY returns to RUN
    exe_multicycle = 1;
    adv;
    exe_multicycle = 0;
    look; chk("mcr_busy", w_o, MCF);
    arst_n = 0;
    #1 chk("mcr_rst", w_o, RST);
    adv;
    arst_n = 1;
    look; chk("mcr_run", w_o, DEF);
    adv;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
